// File: rtl/instr_encoder.sv
// Y86-style instruction encoder: serialises one accepted instruction into
// instruction memory one byte per cycle, with bound checking and halt tracking.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [63:0] valC,
    input  logic        addr_load,
    input  logic [63:0] addr_in,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        instr_invalid,
    output logic        imem_error,
    output logic        HLT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [63:0] MEM_TOP = 64'd1023;

    state_t      state_r;
    logic [63:0] ptr_r;
    logic [3:0]  idx_r;
    logic [3:0]  len_r;
    logic [3:0]  icode_r;
    logic [3:0]  ra_r;
    logic [3:0]  rb_r;
    logic [63:0] valc_r;
    logic        mem_we_r;
    logic [63:0] mem_addr_r;
    logic [7:0]  mem_data_r;
    logic        instr_invalid_r;
    logic        imem_error_r;
    logic        hlt_r;

    logic [3:0]  accept_len_s;
    logic [63:0] ptr_inc_s;
    logic [3:0]  next_idx_s;
    logic        last_byte_s;
    logic [7:0]  next_byte_s;

    // Encoded length per icode; zero marks an icode that is rejected.
    function automatic logic [3:0] enc_len(input logic [3:0] code);
        case (code)
            4'h0, 4'h1, 4'h9:       enc_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: enc_len = 4'd2;
            4'h7, 4'h8:             enc_len = 4'd9;
            4'h3, 4'h4, 4'h5:       enc_len = 4'd10;
            default:                enc_len = 4'd0;
        endcase
    endfunction

    // Byte at position idx >= 1: register byte when present, then valC MSB first.
    function automatic logic [7:0] byte_sel(input logic [3:0] a, input logic [3:0] b,
                                            input logic [63:0] c, input logic [3:0] idx,
                                            input logic [3:0] len);
        logic [3:0]  vidx;
        logic [6:0]  sh;
        logic [63:0] shifted;
        vidx    = 4'd0;
        sh      = 7'd0;
        shifted = 64'd0;
        if ((len == 4'd2 || len == 4'd10) && idx == 4'd1) begin
            byte_sel = {a, b};
        end else begin
            vidx     = (len == 4'd10) ? (idx - 4'd2) : (idx - 4'd1);
            sh       = {vidx, 3'b000};
            shifted  = c << sh;
            byte_sel = shifted[63:56];
        end
    endfunction

    // Lookahead values for the byte that follows the one being written now.
    always_comb begin
        accept_len_s = enc_len(icode);
        ptr_inc_s    = ptr_r + 64'd1;
        next_idx_s   = idx_r + 4'd1;
        last_byte_s  = (next_idx_s == len_r);
        next_byte_s  = byte_sel(ra_r, rb_r, valc_r, next_idx_s, len_r);
    end

    assign in_ready      = (state_r == IDLE) && !addr_load;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_data      = mem_data_r;
    assign instr_invalid = instr_invalid_r;
    assign imem_error    = imem_error_r;
    assign HLT           = hlt_r;

    // Controller: outputs are loaded one edge ahead so each EMIT cycle presents its byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            ptr_r           <= 64'd0;
            idx_r           <= 4'd0;
            len_r           <= 4'd0;
            icode_r         <= 4'd0;
            ra_r            <= 4'd0;
            rb_r            <= 4'd0;
            valc_r          <= 64'd0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= 64'd0;
            mem_data_r      <= 8'd0;
            instr_invalid_r <= 1'b0;
            imem_error_r    <= 1'b0;
            hlt_r           <= 1'b0;
        end else begin
            mem_we_r        <= 1'b0;
            instr_invalid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (addr_load) begin
                        ptr_r <= addr_in;
                    end else if (in_valid) begin
                        if (accept_len_s == 4'd0) begin
                            instr_invalid_r <= 1'b1;
                        end else begin
                            icode_r    <= icode;
                            ra_r       <= ra;
                            rb_r       <= rb;
                            valc_r     <= valC;
                            len_r      <= accept_len_s;
                            idx_r      <= 4'd0;
                            state_r    <= EMIT;
                            mem_we_r   <= (ptr_r <= MEM_TOP);
                            mem_addr_r <= ptr_r;
                            mem_data_r <= {icode, ifun};
                        end
                    end
                end
                EMIT: begin
                    if (ptr_r > MEM_TOP) begin
                        state_r      <= ERR;
                        imem_error_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_inc_s;
                        if (last_byte_s) begin
                            state_r <= IDLE;
                            idx_r   <= 4'd0;
                            if (icode_r == 4'h0) begin
                                hlt_r <= 1'b1;
                            end
                        end else begin
                            idx_r      <= next_idx_s;
                            mem_we_r   <= (ptr_inc_s <= MEM_TOP);
                            mem_addr_r <= ptr_inc_s;
                            mem_data_r <= next_byte_s;
                        end
                    end
                end
                ERR: begin
                    state_r <= ERR;
                end
                default: begin
                    state_r <= ERR;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: in_valid  input  1  encode request carrying icode/ifun/ra/rb/valC.
REQ-004: in_ready  output  1  encoder can accept a request this cycle.
REQ-005: icode, ifun, ra, rb  input  4 each  instruction fields.
REQ-006: valC  input  64  constant field, signed, two's complement.
REQ-007: addr_load  input  1  load write pointer from addr_in.
REQ-008: addr_in  input  64  new write-pointer value.
REQ-009: mem_we  output  1  byte-write strobe to instruction memory.
REQ-010: mem_addr  output  64  byte address, valid when mem_we=1.
REQ-011: mem_data  output  8  byte value, valid when mem_we=1.
REQ-012: instr_invalid  output  1  one-cycle pulse on rejected icode.
REQ-013: imem_error  output  1  sticky; write attempted above address 1023.
REQ-014: HLT  output  1  sticky; a halt instruction has been fully written.

Function
REQ-015: FSM states IDLE, EMIT, ERR.
REQ-016: in_ready SHALL be 1 only in IDLE with addr_load=0.
REQ-017: A request is accepted when in_valid=1 and in_ready=1; all fields are latched that cycle.
REQ-018: Encoded length by icode: 0,1,9 -> 1 byte; 2,6,A,B -> 2 bytes; 7,8 -> 9 bytes; 3,4,5 -> 10 bytes.
REQ-019: Byte 0 = {icode,ifun}; if length is 2 or 10, byte 1 = {ra,rb}; valC follows as 8 bytes, valC[63:56] first, valC[7:0] last.
REQ-020: ra/rb are not emitted for icodes 0,1,7,8,9 regardless of input value.
REQ-021: Accept with valid length -> EMIT; first write occurs the cycle after acceptance; one byte written per cycle, no gaps.
REQ-022: Each EMIT cycle: mem_we=1, mem_addr=write pointer, mem_data=current byte; write pointer and byte index increment by 1.
REQ-023: After the last byte, return to IDLE; in_ready=1 the following cycle (throughput: length+1 cycles per instruction).
REQ-024: icode C-F accepted and dropped: no writes, pointer unchanged, instr_invalid=1 for exactly the cycle after acceptance, FSM stays IDLE.
REQ-025: addr_load in IDLE sets pointer to addr_in next cycle; addr_load outside IDLE is ignored; addr_load has priority over in_valid (request not accepted).
REQ-026: Bound check: if pointer > 1023 in an EMIT cycle, mem_we=0 that cycle, imem_error set, FSM -> ERR; remaining bytes discarded.
REQ-027: ERR is absorbing: in_ready=0, mem_we=0, addr_load ignored until reset.
REQ-028: HLT set in the cycle after the byte 0x00 of an icode-0 request is written; encoder keeps accepting requests afterward.
REQ-029: mem_we=0 in IDLE and ERR; mem_addr/mem_data are don't-care when mem_we=0.
REQ-030: Pointer arithmetic is 64-bit unsigned; wrap is unreachable because ERR triggers at 1024.

Reset
REQ-031: reset=1 at a clock edge forces IDLE, pointer=0, byte index=0, mem_we=0, instr_invalid=0, imem_error=0, HLT=0, in_ready=1 next cycle.
REQ-032: Reset has priority over every input and state, including mid-EMIT; a partially written instruction is abandoned with no further writes.

Verification
REQ-033: reset; irmovq icode=3 ifun=0 ra=F rb=2 valC=0x10 -> 10 writes at 0..9: 30 F2 00 00 00 00 00 00 00 10; in_ready=1 at cycle 11 after accept.
REQ-034: then jmp icode=7 ifun=0 valC=0x0123456789ABCDEF -> 9 writes at 10..18: 70 01 23 45 67 89 AB CD EF.
REQ-035: addr_load addr_in=1020; mrmovq -> writes at 1020..1023 only, no write at 1024, imem_error=1, FSM in ERR, in_ready stays 0.
REQ-036: icode=C -> zero writes, instr_invalid high exactly 1 cycle, next request written at the unchanged pointer.
REQ-037: call accepted, reset asserted after 3 bytes written -> mem_we=0 next cycle, pointer=0, in_ready=1.
REQ-038: halt at pointer 5 -> single write 00 at 5, HLT=1 next cycle; nop following -> write 10 at 6, HLT remains 1.
